// File: rtl/sccb_pkg.sv
// ---------------------------------------------------------------------------
// sccb_pkg
//   Shared definitions for the SCCB responder and the master's bench:
//   synchronizer depth, FSM state encoding, bus event encoding and the
//   event decoder used on synchronized clock/data samples.
// ---------------------------------------------------------------------------
package sccb_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_X,
        ST_SUB,
        ST_SUB_X,
        ST_WR_DATA,
        ST_WR_X,
        ST_RD_DATA,
        ST_RD_X,
        ST_IGNORE
    } sccb_state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_START,
        EV_STOP,
        EV_RISE,
        EV_FALL
    } sccb_event_e;

    // START/STOP need c stable high across both samples, so a c edge that
    // coincides with a d change is always reported as the c edge.
    function automatic sccb_event_e decode_event(input logic c_prev, input logic c_cur,
                                                 input logic d_prev, input logic d_cur);
        if (c_prev && c_cur) begin
            if (d_prev && !d_cur) return EV_START;
            if (!d_prev && d_cur) return EV_STOP;
            return EV_NONE;
        end
        if (!c_prev && c_cur) return EV_RISE;
        if (c_prev && !c_cur) return EV_FALL;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/sccb_slave_regfile.sv
// ---------------------------------------------------------------------------
// sccb_slave_regfile
//   NREGS x 8 register file: synchronous write, asynchronous read,
//   every entry reset to RESET_VAL. Out-of-range reads return 8'hFF and
//   out-of-range writes are dropped.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_en/addr/data   write port
//   rd_addr, rd_data  combinational read port
// ---------------------------------------------------------------------------
module sccb_slave_regfile #(
    parameter int          NREGS     = 256,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [NREGS];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the whole array is reset because registers must come up at
    // RESET_VAL; this makes it flops rather than an inferred RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= RESET_VAL;
        end else if (wr_en && (int'(wr_addr) < NREGS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb rd_data = (int'(rd_addr) < NREGS) ? mem[rd_addr] : 8'hFF;

endmodule

// File: rtl/sccb_slave.sv
// ---------------------------------------------------------------------------
// sccb_slave
//   Camera-side SCCB responder. Oversamples sccb_c/sccb_d on clk, decodes
//   START/STOP and the ID, sub-address and data phases, writes the register
//   file on 3-phase writes and drives register data on reads.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sccb_c          serial clock from master
//   sccb_d          serial data (driven only while sd_oe=1)
//   sd_oe           copy of the sccb_d output enable
//   reg_wr_en       one-cycle pulse per register write, with addr/data
//   reg_wr_addr     sub-address of the last write
//   reg_wr_data     data of the last write
//   cur_subaddr     latched sub-address
//   busy            high from START detect until STOP detect
//   id_err          one-cycle pulse on an ID mismatch
// ---------------------------------------------------------------------------
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID    = 7'h50,
    parameter int         NREGS     = 256,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sccb_c,
    inout  wire        sccb_d,
    output logic       sd_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] cur_subaddr,
    output logic       busy,
    output logic       id_err
);

    logic [SYNC_STAGES-1:0] c_pipe, d_pipe;
    logic        c_prev, d_prev;
    logic        c_sync, d_sync;
    sccb_event_e ev;
    sccb_state_e state, state_next;

    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  rx_byte;
    logic        rise, fall, byte_done, id_match;
    logic        rw_bit;
    logic [7:0]  tx_shift;
    logic        rd_done;
    logic [7:0]  rd_data;

    // Input conditioning: synchronizer chain plus one history stage.
    // Flops reset to 1 (idle bus) so leaving reset raises no spurious event.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_pipe <= '1;
            d_pipe <= '1;
            c_prev <= 1'b1;
            d_prev <= 1'b1;
        end else begin
            c_pipe <= {c_pipe[SYNC_STAGES-2:0], sccb_c};
            d_pipe <= {d_pipe[SYNC_STAGES-2:0], sccb_d};
            c_prev <= c_sync;
            d_prev <= d_sync;
        end
    end

    assign c_sync    = c_pipe[SYNC_STAGES-1];
    assign d_sync    = d_pipe[SYNC_STAGES-1];
    assign ev        = decode_event(c_prev, c_sync, d_prev, d_sync);
    assign rise      = (ev == EV_RISE);
    assign fall      = (ev == EV_FALL);
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign rx_byte   = {shift_in, d_sync};
    assign id_match  = (rx_byte[7:1] == DEV_ID);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; START/STOP override every state.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        if (ev == EV_START) begin
            state_next = ST_ID;
        end else if (ev == EV_STOP) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_ID:      if (byte_done) state_next = id_match ? ST_ID_X : ST_IGNORE;
                ST_ID_X:    if (rise) state_next = rw_bit ? ST_RD_DATA : ST_SUB;
                ST_SUB:     if (byte_done) state_next = ST_SUB_X;
                ST_SUB_X:   if (rise) state_next = ST_WR_DATA;
                ST_WR_DATA: if (byte_done) state_next = ST_WR_X;
                ST_WR_X:    if (rise) state_next = ST_IGNORE;
                ST_RD_DATA: if (fall && rd_done) state_next = ST_RD_X;
                ST_RD_X:    if (rise) state_next = ST_IGNORE;
                default:    state_next = state;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Datapath: bit counting, byte capture, write pulse and read shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_in    <= '0;
            rw_bit      <= 1'b0;
            cur_subaddr <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            id_err      <= 1'b0;
            tx_shift    <= '0;
            rd_done     <= 1'b0;
            sd_oe       <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            id_err    <= 1'b0;

            // Counter restarts on every phase entry, including a repeated START.
            if (ev == EV_START || state_next != state) bit_cnt <= '0;
            else if (rise)                              bit_cnt <= bit_cnt + 3'd1;

            if (rise) shift_in <= rx_byte[6:0];

            if (state == ST_ID && byte_done) begin
                rw_bit <= rx_byte[0];
                id_err <= !id_match;
            end

            if (state == ST_SUB && byte_done) cur_subaddr <= rx_byte;

            if (state == ST_WR_DATA && byte_done) begin
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= cur_subaddr;
                reg_wr_data <= rx_byte;
            end

            // Read: first FALL enables the driver with the MSB already in
            // place; each later FALL advances one bit.
            if (state == ST_ID_X && state_next == ST_RD_DATA) begin
                tx_shift <= rd_data;
                rd_done  <= 1'b0;
            end else if (state == ST_RD_DATA) begin
                if (byte_done)          rd_done  <= 1'b1;
                if (fall && sd_oe)      tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if (state_next != ST_RD_DATA)                  sd_oe <= 1'b0;
            else if (state == ST_RD_DATA && fall && !sd_oe) sd_oe <= 1'b1;
        end
    end

    assign sccb_d = sd_oe ? tx_shift[7] : 1'bz;

    sccb_slave_regfile #(
        .NREGS     (NREGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (reg_wr_en),
        .wr_addr (reg_wr_addr),
        .wr_data (reg_wr_data),
        .rd_addr (cur_subaddr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sccb_slave.sv
// ---------------------------------------------------------------------------
// tb_sccb_slave
//   Directed bench for sccb_slave: a bit-banged SCCB master drives the bus
//   at 8 system clocks per half period; monitors count write pulses, id_err
//   cycles and output-enable cycles.
// ---------------------------------------------------------------------------
module tb_sccb_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sc;
    logic       m_oe;
    logic       m_d;
    wire        sccb_d;
    logic       sd_oe;
    logic       reg_wr_en;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] cur_subaddr;
    logic       busy;
    logic       id_err;

    assign sccb_d = m_oe ? m_d : 1'bz;

    sccb_slave dut (
        .clk         (clk),
        .rst         (rst),
        .sccb_c      (sc),
        .sccb_d      (sccb_d),
        .sd_oe       (sd_oe),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .cur_subaddr (cur_subaddr),
        .busy        (busy),
        .id_err      (id_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int         wr_cnt  = 0;
    int         err_cnt = 0;
    int         oe_cnt  = 0;
    logic [7:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (id_err) err_cnt = err_cnt + 1;
        if (sd_oe)  oe_cnt  = oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_oe = 1'b1;
        m_d  = 1'b1;
        tick(H);
        sc = 1'b1;
        tick(H);
        m_d = 1'b0;
        tick(H);
        sc = 1'b0;
        tick(2);
    endtask

    task automatic send_bit(input logic b);
        m_d = b;
        tick(H);
        sc = 1'b1;
        tick(H);
        sc = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic bus_stop(input bit chk_latency);
        m_oe = 1'b1;
        m_d  = 1'b0;
        tick(H);
        sc = 1'b1;
        tick(H);
        m_d = 1'b1;
        if (chk_latency) begin
            tick(2);
            check("busy_2cyc_after_stop", 32'(busy), 1);
            tick(1);
            check("busy_3cyc_after_stop", 32'(busy), 0);
        end
        tick(H);
    endtask

    // Called right after the ID_X bit: master releases the line, clocks in
    // eight bits, waits for the slave to let go, then sends NA.
    task automatic read_byte(output logic [7:0] v);
        m_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick(H);
            if (i == 7) check("rd_oe_on_msb", 32'(sd_oe), 1);
            v[i] = sccb_d;
            sc = 1'b1;
            tick(H);
            sc = 1'b0;
            tick(2);
        end
        tick(4);
        check("rd_released", 32'(sd_oe), 0);
        m_oe = 1'b1;
        m_d  = 1'b1;
        tick(H);
        sc = 1'b1;
        tick(H);
        sc = 1'b0;
        tick(2);
    endtask

    task automatic write3(input logic [7:0] addr, input logic [7:0] data);
        bus_start();
        send_byte(8'hA0); send_bit(1'b0);
        send_byte(addr);  send_bit(1'b0);
        send_byte(data);  send_bit(1'b0);
        bus_stop(1'b0);
    endtask

    task automatic read_at(input logic [7:0] addr, output logic [7:0] v);
        bus_start();
        send_byte(8'hA0); send_bit(1'b0);
        send_byte(addr);  send_bit(1'b0);
        bus_stop(1'b0);
        bus_start();
        send_byte(8'hA1); send_bit(1'b0);
        read_byte(v);
        bus_stop(1'b0);
    endtask

    initial begin
        logic [7:0] rv;
        int w0;
        int e0;
        int o0;

        rst  = 1'b1;
        sc   = 1'b1;
        m_oe = 1'b1;
        m_d  = 1'b1;
        tick(3);
        check("rst_sd_oe",     32'(sd_oe), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_subaddr",   32'(cur_subaddr), 0);
        check("rst_wr_en",     32'(reg_wr_en), 0);
        check("rst_id_err",    32'(id_err), 0);
        rst = 1'b0;
        tick(4);

        // 1: 3-phase write 0x12 = 0xA5
        w0 = wr_cnt;
        bus_start();
        check("t1_busy_after_start", 32'(busy), 1);
        send_byte(8'hA0); send_bit(1'b0);
        send_byte(8'h12); send_bit(1'b0);
        send_byte(8'hA5); send_bit(1'b0);
        bus_stop(1'b1);
        check("t1_wr_count", 32'(wr_cnt - w0), 1);
        check("t1_wr_addr",  32'(last_addr), 'h12);
        check("t1_wr_data",  32'(last_data), 'hA5);
        check("t1_no_id_err", 32'(err_cnt), 0);

        // 2: 2-phase sub-address set, then read back 0xA5
        w0 = wr_cnt;
        bus_start();
        send_byte(8'hA0); send_bit(1'b0);
        send_byte(8'h12); send_bit(1'b0);
        bus_stop(1'b0);
        check("t2_subaddr", 32'(cur_subaddr), 'h12);
        bus_start();
        send_byte(8'hA1); send_bit(1'b0);
        read_byte(rv);
        bus_stop(1'b0);
        check("t2_read_data", 32'(rv), 'hA5);
        check("t2_no_write",  32'(wr_cnt - w0), 0);

        // 3: wrong ID (0x51, read) is ignored
        w0 = wr_cnt;
        e0 = err_cnt;
        o0 = oe_cnt;
        bus_start();
        send_byte(8'hA3); send_bit(1'b0);
        send_byte(8'hFF); send_bit(1'b0);
        bus_stop(1'b0);
        check("t3_id_err_pulse", 32'(err_cnt - e0), 1);
        check("t3_no_oe",        32'(oe_cnt - o0), 0);
        check("t3_no_write",     32'(wr_cnt - w0), 0);
        check("t3_idle",         32'(busy), 0);

        // 4: STOP after 4 data bits discards the byte
        w0 = wr_cnt;
        bus_start();
        send_byte(8'hA0); send_bit(1'b0);
        send_byte(8'h05); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop(1'b0);
        check("t4_idle",     32'(busy), 0);
        check("t4_no_write", 32'(wr_cnt - w0), 0);
        write3(8'h03, 8'h3C);
        check("t4_wr_count", 32'(wr_cnt - w0), 1);
        check("t4_wr_addr",  32'(last_addr), 'h03);
        check("t4_wr_data",  32'(last_data), 'h3C);
        read_at(8'h03, rv);
        check("t4_readback", 32'(rv), 'h3C);

        // 5: reset in the middle of a read
        bus_start();
        send_byte(8'hA0); send_bit(1'b0);
        send_byte(8'h12); send_bit(1'b0);
        bus_stop(1'b0);
        bus_start();
        send_byte(8'hA1); send_bit(1'b0);
        m_oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(H);
            sc = 1'b1;
            tick(H);
            sc = 1'b0;
            tick(2);
        end
        tick(H / 2);
        check("t5_oe_before_rst", 32'(sd_oe), 1);
        rst = 1'b1;
        tick(1);
        check("t5_rst_sd_oe",   32'(sd_oe), 0);
        check("t5_rst_busy",    32'(busy), 0);
        check("t5_rst_subaddr", 32'(cur_subaddr), 0);
        rst  = 1'b0;
        m_oe = 1'b1;
        m_d  = 1'b1;
        tick(2);
        read_at(8'h12, rv);
        check("t5_reg_reset", 32'(rv), 'h00);

        // 6: repeated START during SUB, then a full write
        w0 = wr_cnt;
        bus_start();
        send_byte(8'hA0); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        bus_start();
        send_byte(8'hA0); send_bit(1'b0);
        send_byte(8'h20); send_bit(1'b0);
        send_byte(8'h7E); send_bit(1'b0);
        bus_stop(1'b0);
        check("t6_wr_count", 32'(wr_cnt - w0), 1);
        check("t6_wr_addr",  32'(last_addr), 'h20);
        check("t6_wr_data",  32'(last_data), 'h7E);
        read_at(8'h20, rv);
        check("t6_readback", 32'(rv), 'h7E);
        check("t6_no_id_err", 32'(err_cnt - e0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
